// File: rtl/drc_frame_asm_if.sv
// drc_frame_asm_if -- pixel stream bundle for the DVP frame assembler.
//
// Handshake semantics (both directions): a beat transfers on a rising clock
// edge where vld and rdy are both high. A source that raises vld keeps its
// payload stable until that edge; rdy may depend combinationally on the
// opposite side's rdy but never on the same side's vld.
//
// bwd_*  : byte beats {vsync, hsync, byte} flowing into the assembler.
// fwd_*  : assembled pixels flowing out of the assembler.
interface drc_frame_asm_if #(
    parameter int DVP_DATA_W   = 8,
    parameter int PXL_BYTE_MAX = 3
);
    localparam int PXL_INFO_W = DVP_DATA_W + 2;
    localparam int OUT_PXL_W  = DVP_DATA_W * PXL_BYTE_MAX;

    logic [PXL_INFO_W-1:0] bwd_pxl_info_dat;
    logic                  bwd_pxl_info_vld;
    logic                  bwd_pxl_info_rdy;
    logic [OUT_PXL_W-1:0]  fwd_pxl_dat;
    logic                  fwd_pxl_last;
    logic                  fwd_pxl_vld;
    logic                  fwd_pxl_rdy;

    // Environment side: supplies byte beats, consumes pixels.
    modport master (
        output bwd_pxl_info_dat,
        output bwd_pxl_info_vld,
        input  bwd_pxl_info_rdy,
        input  fwd_pxl_dat,
        input  fwd_pxl_last,
        input  fwd_pxl_vld,
        output fwd_pxl_rdy
    );

    // Assembler side: consumes byte beats, produces pixels.
    modport slave (
        input  bwd_pxl_info_dat,
        input  bwd_pxl_info_vld,
        output bwd_pxl_info_rdy,
        output fwd_pxl_dat,
        output fwd_pxl_last,
        output fwd_pxl_vld,
        input  fwd_pxl_rdy
    );
endinterface

// File: rtl/drc_frame_asm.sv
// drc_frame_asm -- assembles DVP byte beats into pixels of 1..3 bytes and
// frames them by img_width x img_height, with sticky interrupt status and
// an error code for malformed frames.
//
// Optional feature: define DRC_FRM_TIMEOUT_EN to build a stall watchdog that
// raises error 100 after TIMEOUT_CYC consecutive CAPTURE cycles with no
// accepted beat. Without the macro no watchdog logic is built.
module drc_frame_asm #(
    parameter int DVP_DATA_W   = 8,
    parameter int PXL_BYTE_MAX = 3,
    parameter int IMG_DIM_MAX  = 640,
    parameter int IMG_DIM_W    = $clog2(IMG_DIM_MAX + 1),
    parameter int TIMEOUT_CYC  = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    drc_frame_asm_if.slave       pxl,
    input  logic                 cfg_en,
    input  logic [1:0]           cfg_mode,
    input  logic                 cfg_cont,
    input  logic                 cfg_start,
    input  logic [IMG_DIM_W-1:0] img_width,
    input  logic [IMG_DIM_W-1:0] img_height,
    input  logic [1:0]           irq_msk,
    input  logic [1:0]           irq_clr,
    output logic [1:0]           irq_sts,
    output logic [2:0]           sts_state,
    output logic [2:0]           sts_err,
    output logic                 irq
);
    localparam int PXL_INFO_W = DVP_DATA_W + 2;
    localparam int OUT_PXL_W  = DVP_DATA_W * PXL_BYTE_MAX;
    localparam int BC_W       = $clog2(PXL_BYTE_MAX + 1);

    localparam logic [IMG_DIM_W-1:0] DIM_ONE = IMG_DIM_W'(1);
    localparam logic [BC_W-1:0]      BC_ONE  = BC_W'(1);

    localparam logic [2:0] ERR_NONE  = 3'b000;
    localparam logic [2:0] ERR_ALIGN = 3'b001;
    localparam logic [2:0] ERR_LINE  = 3'b010;
    localparam logic [2:0] ERR_FRAME = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b000,
        ST_WAIT_SOF = 3'b001,
        ST_CAPTURE  = 3'b010,
        ST_ERROR    = 3'b011
    } state_e;

    state_e                 state_q, state_d;
    logic [BC_W-1:0]        nbytes_q, nbytes_d;
    logic [IMG_DIM_W-1:0]   width_q, width_d;
    logic [IMG_DIM_W-1:0]   height_q, height_d;
    logic [BC_W-1:0]        byte_cnt_q, byte_cnt_d;
    logic [IMG_DIM_W-1:0]   col_q, col_d;
    logic [IMG_DIM_W-1:0]   row_q, row_d;
    logic [OUT_PXL_W-1:0]   acc_q, acc_d;
    logic                   frame_done_q, frame_done_d;
    logic                   out_vld_q, out_vld_d;
    logic [OUT_PXL_W-1:0]   out_dat_q, out_dat_d;
    logic                   out_last_q, out_last_d;
    logic [2:0]             err_q, err_d;
    logic [1:0]             irq_sts_q, irq_sts_d;
    logic                   irq_q, irq_d;

`ifdef DRC_FRM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [2:0] ERR_TMO = 3'b100;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
`endif

    // Per-cycle working values.
    logic                   bwd_rdy;
    logic                   beat_acc;
    logic                   beat_vsync;
    logic                   beat_hsync;
    logic [DVP_DATA_W-1:0]  beat_byte;
    logic                   out_take;
    logic [1:0]             sts_set;
    logic                   err_hit;
    logic [2:0]             err_code;
    logic [IMG_DIM_W-1:0]   col_v;
    logic [IMG_DIM_W-1:0]   row_v;
    logic [OUT_PXL_W-1:0]   acc_v;
    logic                   last_v;

    // Input beats are always swallowed outside CAPTURE; in CAPTURE they are
    // taken only when the single-entry output register has room this cycle.
    assign bwd_rdy    = (state_q == ST_CAPTURE) ? !(out_vld_q && !pxl.fwd_pxl_rdy) : 1'b1;
    assign beat_acc   = pxl.bwd_pxl_info_vld && bwd_rdy;
    assign beat_vsync = pxl.bwd_pxl_info_dat[PXL_INFO_W-1];
    assign beat_hsync = pxl.bwd_pxl_info_dat[PXL_INFO_W-2];
    assign beat_byte  = pxl.bwd_pxl_info_dat[DVP_DATA_W-1:0];
    assign out_take   = out_vld_q && pxl.fwd_pxl_rdy;

    assign pxl.bwd_pxl_info_rdy = bwd_rdy;
    assign pxl.fwd_pxl_dat      = out_dat_q;
    assign pxl.fwd_pxl_last     = out_last_q;
    assign pxl.fwd_pxl_vld      = out_vld_q;
    assign irq_sts              = irq_sts_q;
    assign sts_state            = state_q;
    assign sts_err              = err_q;
    assign irq                  = irq_q;

    // Next-state, datapath and status logic for the frame FSM.
    always_comb begin
        state_d      = state_q;
        nbytes_d     = nbytes_q;
        width_d      = width_q;
        height_d     = height_q;
        byte_cnt_d   = byte_cnt_q;
        col_d        = col_q;
        row_d        = row_q;
        acc_d        = acc_q;
        frame_done_d = frame_done_q;
        out_vld_d    = out_vld_q;
        out_dat_d    = out_dat_q;
        out_last_d   = out_last_q;
        err_d        = err_q;
        sts_set      = 2'b00;
        err_hit      = 1'b0;
        err_code     = ERR_NONE;
        col_v        = col_q;
        row_v        = row_q;
        acc_v        = (acc_q << DVP_DATA_W) | OUT_PXL_W'(beat_byte);
        last_v       = 1'b0;
`ifdef DRC_FRM_TIMEOUT_EN
        tmo_d        = '0;
`endif

        // The output register drains on its own handshake in every state.
        if (out_take) begin
            out_vld_d = 1'b0;
        end
        // Frame completes when the downstream takes the last pixel.
        if (out_take && out_last_q) begin
            sts_set[0] = 1'b1;
        end

        if (!cfg_en && (state_q != ST_IDLE)) begin
            // Disable: leave as soon as no pixel is stuck in the output.
            if (!out_vld_q || pxl.fwd_pxl_rdy) begin
                state_d      = ST_IDLE;
                byte_cnt_d   = '0;
                col_d        = '0;
                row_d        = '0;
                acc_d        = '0;
                frame_done_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cfg_start && cfg_en && (cfg_mode != 2'b11) &&
                        (img_width != '0) && (img_height != '0)) begin
                        state_d  = ST_WAIT_SOF;
                        width_d  = img_width;
                        height_d = img_height;
                        case (cfg_mode)
                            2'b00:   nbytes_d = BC_W'(1);
                            2'b01:   nbytes_d = BC_W'(2);
                            default: nbytes_d = BC_W'(3);
                        endcase
                    end
                end

                ST_WAIT_SOF: begin
                    if (beat_acc && beat_vsync) begin
                        state_d      = ST_CAPTURE;
                        byte_cnt_d   = '0;
                        col_d        = '0;
                        row_d        = '0;
                        acc_d        = '0;
                        frame_done_d = 1'b0;
                    end
                end

                ST_CAPTURE: begin
                    if (frame_done_q) begin
                        // Frame fully assembled; beats are dropped until the
                        // last pixel is handed over.
                        if (out_take && out_last_q) begin
                            state_d      = cfg_cont ? ST_WAIT_SOF : ST_IDLE;
                            byte_cnt_d   = '0;
                            col_d        = '0;
                            row_d        = '0;
                            acc_d        = '0;
                            frame_done_d = 1'b0;
                        end
                    end else if (beat_acc) begin
                        if (beat_vsync) begin
                            err_hit  = 1'b1;
                            err_code = ERR_FRAME;
                        end else if (beat_hsync && (byte_cnt_q != '0)) begin
                            err_hit  = 1'b1;
                            err_code = ERR_ALIGN;
                        end else if (beat_hsync && !((row_q == '0) && (col_q == '0)) &&
                                     (col_q != width_q)) begin
                            err_hit  = 1'b1;
                            err_code = ERR_LINE;
                        end else if (!beat_hsync && (col_q == width_q)) begin
                            // Line already full and no hsync to open the next.
                            err_hit  = 1'b1;
                            err_code = ERR_LINE;
                        end else begin
                            if (beat_hsync && (col_q == width_q)) begin
                                col_v = '0;
                                row_v = row_q + DIM_ONE;
                            end
                            if ((byte_cnt_q + BC_ONE) == nbytes_q) begin
                                last_v       = (col_v == width_q - DIM_ONE) &&
                                               (row_v == height_q - DIM_ONE);
                                out_vld_d    = 1'b1;
                                out_dat_d    = acc_v;
                                out_last_d   = last_v;
                                frame_done_d = last_v;
                                acc_d        = '0;
                                byte_cnt_d   = '0;
                                col_d        = col_v + DIM_ONE;
                                row_d        = row_v;
                            end else begin
                                acc_d        = acc_v;
                                byte_cnt_d   = byte_cnt_q + BC_ONE;
                                col_d        = col_v;
                                row_d        = row_v;
                            end
                        end
                    end else begin
`ifdef DRC_FRM_TIMEOUT_EN
                        if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                            err_hit  = 1'b1;
                            err_code = ERR_TMO;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
`endif
                    end
                end

                ST_ERROR: begin
                    state_d = cfg_cont ? ST_WAIT_SOF : ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // Any frame error drops the partial pixel and parks in ERROR.
        if (err_hit) begin
            state_d      = ST_ERROR;
            err_d        = err_code;
            sts_set[1]   = 1'b1;
            acc_d        = '0;
            byte_cnt_d   = '0;
            frame_done_d = 1'b0;
        end

        // Sticky status: a set in the same cycle as a clear wins.
        irq_sts_d = (irq_sts_q & ~irq_clr) | sts_set;
        irq_d     = |(irq_sts_d & irq_msk);
    end

    // State, counters, output register and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            nbytes_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            byte_cnt_q   <= '0;
            col_q        <= '0;
            row_q        <= '0;
            acc_q        <= '0;
            frame_done_q <= 1'b0;
            out_vld_q    <= 1'b0;
            out_dat_q    <= '0;
            out_last_q   <= 1'b0;
            err_q        <= ERR_NONE;
            irq_sts_q    <= 2'b00;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            nbytes_q     <= nbytes_d;
            width_q      <= width_d;
            height_q     <= height_d;
            byte_cnt_q   <= byte_cnt_d;
            col_q        <= col_d;
            row_q        <= row_d;
            acc_q        <= acc_d;
            frame_done_q <= frame_done_d;
            out_vld_q    <= out_vld_d;
            out_dat_q    <= out_dat_d;
            out_last_q   <= out_last_d;
            err_q        <= err_d;
            irq_sts_q    <= irq_sts_d;
            irq_q        <= irq_d;
        end
    end

`ifdef DRC_FRM_TIMEOUT_EN
    // Stall watchdog counter: consecutive CAPTURE cycles without a beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif
endmodule

// File: tb/tb_drc_frame_asm.sv
// tb_drc_frame_asm -- directed bench for drc_frame_asm: reset values, RGB565
// frame, start qualification, alignment/line errors, back-pressure, optional
// watchdog and a mid-frame reset.
`timescale 1ns/1ps
module tb_drc_frame_asm;
  localparam int DW    = 8;
  localparam int PBM   = 3;
  localparam int DIM_W = 10;
  localparam int OW    = DW * PBM;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_en;
  logic [1:0]       cfg_mode;
  logic             cfg_cont;
  logic             cfg_start;
  logic [DIM_W-1:0] img_width;
  logic [DIM_W-1:0] img_height;
  logic [1:0]       irq_msk;
  logic [1:0]       irq_clr;
  logic [1:0]       irq_sts;
  logic [2:0]       sts_state;
  logic [2:0]       sts_err;
  logic             irq;

  int total = 0;
  int bad = 0;
  logic [OW:0] exp_q[$];
  logic [OW:0] mon_e;

  drc_frame_asm_if #(.DVP_DATA_W(DW), .PXL_BYTE_MAX(PBM)) pxl ();

  drc_frame_asm #(
    .DVP_DATA_W(DW), .PXL_BYTE_MAX(PBM), .IMG_DIM_MAX(640), .IMG_DIM_W(DIM_W), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pxl(pxl),
    .cfg_en(cfg_en), .cfg_mode(cfg_mode), .cfg_cont(cfg_cont), .cfg_start(cfg_start),
    .img_width(img_width), .img_height(img_height),
    .irq_msk(irq_msk), .irq_clr(irq_clr), .irq_sts(irq_sts),
    .sts_state(sts_state), .sts_err(sts_err), .irq(irq)
  );

  // clock
  always #5 clk = ~clk;

  // global time bound
  initial begin
    #500000;
    $display("FAIL watchdog obs=still_running exp=finished");
    $fatal(1, "bench time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic vs, input logic hs, input logic [DW-1:0] b);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    pxl.bwd_pxl_info_dat = {vs, hs, b};
    pxl.bwd_pxl_info_vld = 1'b1;
    do begin
      @(negedge clk);
      acc = pxl.bwd_pxl_info_rdy;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 200);
    chk("beat_accept", 32'(acc), 32'd1);
    pxl.bwd_pxl_info_vld = 1'b0;
  endtask

  task automatic start_cap(input logic [1:0] m, input int w, input int h, input logic cont);
    cfg_mode   = m;
    img_width  = DIM_W'(w);
    img_height = DIM_W'(h);
    cfg_cont   = cont;
    cfg_start  = 1'b1;
    tick(1);
    cfg_start  = 1'b0;
  endtask

  task automatic clr_irq();
    irq_clr = 2'b11;
    tick(1);
    irq_clr = 2'b00;
  endtask

  task automatic push_pix(input logic last, input logic [OW-1:0] d);
    exp_q.push_back({last, d});
  endtask

  // scoreboard: every transferred pixel is matched against the expected queue
  always @(negedge clk) begin
    if (rst_n && pxl.fwd_pxl_vld && pxl.fwd_pxl_rdy) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL pix_unexpected obs=%0h exp=none", {pxl.fwd_pxl_last, pxl.fwd_pxl_dat});
      end else begin
        mon_e = exp_q.pop_front();
        chk("pix", 32'({pxl.fwd_pxl_last, pxl.fwd_pxl_dat}), 32'(mon_e));
      end
    end
  end

  initial begin
    cfg_en = 1'b1; cfg_mode = 2'b00; cfg_cont = 1'b0; cfg_start = 1'b0;
    img_width = '0; img_height = '0; irq_msk = 2'b11; irq_clr = 2'b00;
    pxl.bwd_pxl_info_dat = '0; pxl.bwd_pxl_info_vld = 1'b0; pxl.fwd_pxl_rdy = 1'b1;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(sts_state), 32'd0);
    chk("rst_vld", 32'(pxl.fwd_pxl_vld), 32'd0);
    chk("rst_dat", 32'(pxl.fwd_pxl_dat), 32'd0);
    chk("rst_last", 32'(pxl.fwd_pxl_last), 32'd0);
    chk("rst_irq_sts", 32'(irq_sts), 32'd0);
    chk("rst_err", 32'(sts_err), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_bwd_rdy", 32'(pxl.bwd_pxl_info_rdy), 32'd1);
    rst_n = 1'b1;
    tick(1);

    // RGB565 4x2 frame, bytes 0x01..0x10
    start_cap(2'b01, 4, 2, 1'b0);
    chk("f565_wait_sof", 32'(sts_state), 32'd1);
    send_beat(1'b1, 1'b0, 8'h00);
    chk("f565_capture", 32'(sts_state), 32'd2);
    for (int p = 0; p < 8; p++) begin
      push_pix(p == 7, OW'({8'(2 * p + 1), 8'(2 * p + 2)}));
    end
    for (int i = 1; i <= 16; i++) begin
      send_beat(1'b0, (i == 1) || (i == 9), 8'(i));
    end
    tick(2);
    chk("f565_irq_sts", 32'(irq_sts), 32'd1);
    chk("f565_state", 32'(sts_state), 32'd0);
    chk("f565_err", 32'(sts_err), 32'd0);
    chk("f565_irq", 32'(irq), 32'd1);
    chk("f565_sb_empty", 32'(exp_q.size()), 32'd0);
    clr_irq();
    chk("clr_irq_sts", 32'(irq_sts), 32'd0);
    chk("clr_irq", 32'(irq), 32'd0);

    // starts that must be ignored
    start_cap(2'b11, 4, 2, 1'b0);
    chk("ign_mode11", 32'(sts_state), 32'd0);
    start_cap(2'b00, 0, 2, 1'b0);
    chk("ign_width0", 32'(sts_state), 32'd0);
    start_cap(2'b00, 4, 0, 1'b0);
    chk("ign_height0", 32'(sts_state), 32'd0);
    cfg_en = 1'b0;
    start_cap(2'b00, 4, 2, 1'b0);
    chk("ign_disabled", 32'(sts_state), 32'd0);
    cfg_en = 1'b1;

    // RGB888 hsync after two bytes of a pixel -> byte misalign
    irq_msk = 2'b10;
    start_cap(2'b10, 2, 2, 1'b0);
    send_beat(1'b1, 1'b0, 8'h00);
    send_beat(1'b0, 1'b1, 8'hA1);
    send_beat(1'b0, 1'b0, 8'hA2);
    send_beat(1'b0, 1'b1, 8'hA3);
    chk("align_state", 32'(sts_state), 32'd3);
    chk("align_err", 32'(sts_err), 32'd1);
    chk("align_irq_sts", 32'(irq_sts), 32'd2);
    chk("align_irq", 32'(irq), 32'd1);
    tick(1);
    chk("align_idle", 32'(sts_state), 32'd0);
    chk("align_no_pix", 32'(pxl.fwd_pxl_vld), 32'd0);
    clr_irq();

    // RAW8 width 4: short line then hsync -> line length, continuous mode
    irq_msk = 2'b11;
    start_cap(2'b00, 4, 2, 1'b1);
    send_beat(1'b1, 1'b0, 8'h00);
    push_pix(1'b0, 24'h000011);
    push_pix(1'b0, 24'h000012);
    push_pix(1'b0, 24'h000013);
    send_beat(1'b0, 1'b1, 8'h11);
    send_beat(1'b0, 1'b0, 8'h12);
    send_beat(1'b0, 1'b0, 8'h13);
    send_beat(1'b0, 1'b1, 8'h14);
    chk("line_state", 32'(sts_state), 32'd3);
    chk("line_err", 32'(sts_err), 32'd2);
    chk("line_irq_sts", 32'(irq_sts), 32'd2);
    tick(1);
    chk("line_cont_wait_sof", 32'(sts_state), 32'd1);
    send_beat(1'b1, 1'b0, 8'h00);
    chk("line_cont_capture", 32'(sts_state), 32'd2);
    cfg_en = 1'b0;
    tick(1);
    chk("disable_idle", 32'(sts_state), 32'd0);
    cfg_en = 1'b1;
    chk("line_sb_empty", 32'(exp_q.size()), 32'd0);
    clr_irq();

`ifdef DRC_FRM_TIMEOUT_EN
    // watchdog: 16 idle CAPTURE cycles -> error 100
    start_cap(2'b00, 4, 2, 1'b0);
    send_beat(1'b1, 1'b0, 8'h00);
    push_pix(1'b0, 24'h000031);
    send_beat(1'b0, 1'b1, 8'h31);
    tick(15);
    chk("tmo_still_capture", 32'(sts_state), 32'd2);
    tick(1);
    chk("tmo_state", 32'(sts_state), 32'd3);
    chk("tmo_err", 32'(sts_err), 32'd4);
    tick(1);
    chk("tmo_idle", 32'(sts_state), 32'd0);
    clr_irq();
`endif

    // back-pressure for 10 cycles mid-frame, RGB565 4x1
    start_cap(2'b01, 4, 1, 1'b0);
    send_beat(1'b1, 1'b0, 8'h00);
    push_pix(1'b0, 24'h002122);
    push_pix(1'b0, 24'h002324);
    push_pix(1'b0, 24'h002526);
    push_pix(1'b1, 24'h002728);
    send_beat(1'b0, 1'b1, 8'h21);
    send_beat(1'b0, 1'b0, 8'h22);
    tick(1);
    pxl.fwd_pxl_rdy = 1'b0;
    send_beat(1'b0, 1'b0, 8'h23);
    send_beat(1'b0, 1'b0, 8'h24);
    pxl.bwd_pxl_info_dat = {1'b0, 1'b0, 8'h25};
    pxl.bwd_pxl_info_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_bwd_rdy", 32'(pxl.bwd_pxl_info_rdy), 32'd0);
      chk("bp_dat_stable", 32'(pxl.fwd_pxl_dat), 32'h002324);
      chk("bp_vld", 32'(pxl.fwd_pxl_vld), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("bp_state", 32'(sts_state), 32'd2);
    pxl.fwd_pxl_rdy = 1'b1;
    send_beat(1'b0, 1'b0, 8'h25);
    send_beat(1'b0, 1'b0, 8'h26);
    send_beat(1'b0, 1'b0, 8'h27);
    send_beat(1'b0, 1'b0, 8'h28);
    tick(2);
    chk("bp_done_state", 32'(sts_state), 32'd0);
    chk("bp_irq_sts", 32'(irq_sts), 32'd1);
    chk("bp_irq", 32'(irq), 32'd1);
    chk("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // reset pulsed mid-frame with a pixel stuck in the output register
    start_cap(2'b01, 4, 2, 1'b0);
    send_beat(1'b1, 1'b0, 8'h00);
    push_pix(1'b0, 24'h004142);
    send_beat(1'b0, 1'b1, 8'h41);
    send_beat(1'b0, 1'b0, 8'h42);
    tick(1);
    pxl.fwd_pxl_rdy = 1'b0;
    send_beat(1'b0, 1'b0, 8'h43);
    send_beat(1'b0, 1'b0, 8'h44);
    chk("mid_pending", 32'(pxl.fwd_pxl_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(sts_state), 32'd0);
    chk("mid_rst_vld", 32'(pxl.fwd_pxl_vld), 32'd0);
    chk("mid_rst_dat", 32'(pxl.fwd_pxl_dat), 32'd0);
    chk("mid_rst_last", 32'(pxl.fwd_pxl_last), 32'd0);
    chk("mid_rst_irq_sts", 32'(irq_sts), 32'd0);
    chk("mid_rst_err", 32'(sts_err), 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_bwd_rdy", 32'(pxl.bwd_pxl_info_rdy), 32'd1);
    tick(2);
    rst_n = 1'b1;
    pxl.fwd_pxl_rdy = 1'b1;
    tick(2);
    chk("post_rst_state", 32'(sts_state), 32'd0);
    chk("post_rst_vld", 32'(pxl.fwd_pxl_vld), 32'd0);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
